uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter byte interface (9-bit data plus valid) among N_REQ independent requesters, e.g. CPU CSR path, DMA and debug console.
- Round-robin arbitration with packet lock: once granted, a requester owns the transmitter until its byte flagged last is accepted.
- A stall timeout reclaims the transmitter from a requester that stops supplying data mid-packet.
- Sits between the requesters and the uart_tx data input, in the clk domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 9, frame data width (matches the UART 9-bit data path)
TIMEOUT_W, 16, width of the stall counter
TIMEOUT_CYCLES, 1024, clk cycles of requester starvation before forced release; 0 disables the timeout

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
enable_i  input  1  arbitration enable; low means no new grants
req_valid_i  input  N_REQ  per-requester byte valid
req_data_i  input  N_REQ*DATA_W  per-requester byte; slice i = [i*DATA_W +: DATA_W]
req_last_i  input  N_REQ  byte is the last of its packet
req_ready_o  output  N_REQ  per-requester byte accepted when valid&ready
tx_d_o  output  DATA_W  byte to transmitter
tx_d_valid_o  output  1  byte valid to transmitter
tx_d_ready_i  input  1  transmitter can accept a byte (holding register empty)
grant_o  output  N_REQ  one-hot current owner, 0 when idle
grant_id_o  output  $clog2(N_REQ)  index of owner (last owner when idle)
busy_o  output  1  packet in progress
timeout_o  output  1  one-cycle pulse on forced release
timeout_id_o  output  $clog2(N_REQ)  requester released by timeout, held until next timeout

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - rr pointer 0, so requester 0 wins the first contention
  - stall counter 0
- FSM states: IDLE, LOCKED.
- IDLE -> LOCKED when enable_i=1 and any req_valid_i=1.
  - Winner is the first asserted valid searching upward from pointer, wrapping modulo N_REQ.
  - grant_o, grant_id_o and busy_o are registered on that edge.
  - Latency valid->grant is 1 cycle; no byte passes in IDLE, so req_ready_o=0 and tx_d_valid_o=0 there.
- LOCKED, owner g, combinational pass-through:
  - tx_d_o = data[g]
  - tx_d_valid_o = req_valid_i[g]
  - req_ready_o[g] = tx_d_ready_i; all other ready bits 0
- Handshake occurs when req_valid_i[g] & tx_d_ready_i.
  - Handshake with req_last_i[g]=1: next state IDLE, pointer <= g+1 mod N_REQ, grant cleared.
  - There is one idle cycle between packets.
- Stall counter, active only in LOCKED:
  - Increments each cycle req_valid_i[g]=0.
  - Clears on every handshake and on entering LOCKED.
  - Cycles with valid=1 and ready=0 are transmitter backpressure and do not count.
  - Counter saturates; it never wraps.
- Timeout: counter == TIMEOUT_CYCLES-1 with valid still low:
  - Pulse timeout_o for one cycle.
  - timeout_id_o <= g, pointer <= g+1, go IDLE.
  - Later bytes from g start a new arbitration.
- enable_i deassert:
  - In IDLE, blocks grants.
  - In LOCKED, has no effect; the packet completes. No mid-packet abort via enable.
- Single-byte packet (last on first byte) is legal: LOCKED lasts at least one cycle.
- Reset mid-packet: immediate return to reset values; the partially sent packet is not resumed.
- Requester valid/data/last must stay stable until ready; no check is made.

Decomposition:
- uart_defs package gains:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} ArbState_t
  - localparam default TIMEOUT_CYCLES
- Sub-module uart_rr_arbiter:
  - Purely combinational rotating-priority picker.
  - Inputs: req vector, pointer. Outputs: one-hot grant, index, any.
  - Instantiated once; reusable for a future RX fan-out.

Test Plan:
- Req1 sends 3-byte packet 0x041,0x042,0x143(last), tx_d_ready_i always 1 -> grant_o=0010 one cycle after valid; tx sees 3 bytes on consecutive cycles; IDLE after third.
- Req0 and req2 both valid from reset with 2-byte packets -> order req0 then req2; then req0 again valid with req2 -> req2 wins next (pointer=3 wraps search to 0 only if 3 idle; check req2 after req0 when pointer=1).
- Req3 mid-packet, req1 raises valid -> req1 ready stays 0 until req3 last accepted, then req1 granted after 1 idle cycle.
- tx_d_ready_i low 5000 cycles with req valid held -> no timeout, byte held stable, accepted when ready rises.
- Req2 sends 1 byte (no last) then drops valid, TIMEOUT_CYCLES=16 -> timeout_o pulse 16 cycles later, timeout_id_o=2, pointer=3, IDLE.
- enable_i low during req0 packet -> packet completes; pending req1 not granted until enable_i high. rst_n low mid-packet -> all outputs 0 asynchronously, pointer 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_defs: shared types and defaults for the UART transmit path
package uart_defs;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} ArbState_t;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational rotating-priority picker; search starts at ptr and wraps
module uart_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of the UART transmit byte interface
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 9,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]         tx_d_o,
  output logic                      tx_d_valid_o,
  input  logic                      tx_d_ready_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic [IW-1:0]             grant_id_o,
  output logic                      busy_o,
  output logic                      timeout_o,
  output logic [IW-1:0]             timeout_id_o
);
  ArbState_t state, state_n;
  logic [IW-1:0] ptr, pick_idx, nxt_id;
  logic [N_REQ-1:0] pick_grant;
  logic pick_any, locked, owner_valid, hs, done, stall_to;
  logic [TIMEOUT_W-1:0] stall_cnt;

  uart_rr_arbiter #(.N(N_REQ)) u_rr (
    .req(req_valid_i),
    .ptr(ptr),
    .grant(pick_grant),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    locked = state == ARB_LOCKED;
    owner_valid = req_valid_i[grant_id_o];
    hs = locked && owner_valid && tx_d_ready_i;
    done = hs && req_last_i[grant_id_o];
    stall_to = locked && !owner_valid && TIMEOUT_CYCLES != 0 &&
               stall_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    nxt_id = grant_id_o == IW'(N_REQ - 1) ? '0 : grant_id_o + 1'b1;
    tx_d_o = locked ? req_data_i[grant_id_o*DATA_W +: DATA_W] : '0;
    tx_d_valid_o = locked && owner_valid;
    req_ready_o = (locked && tx_d_ready_i) ? N_REQ'(1) << grant_id_o : '0;
    state_n = locked ? ((done || stall_to) ? ARB_IDLE : ARB_LOCKED)
                     : ((enable_i && pick_any) ? ARB_LOCKED : ARB_IDLE);
  end

  // only owner starvation counts toward the timeout; backpressure holds the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr <= '0;
      stall_cnt <= '0;
      grant_o <= '0;
      grant_id_o <= '0;
      busy_o <= 1'b0;
      timeout_o <= 1'b0;
      timeout_id_o <= '0;
    end else begin
      state <= state_n;
      timeout_o <= stall_to;
      if (!locked && state_n == ARB_LOCKED) begin
        grant_o <= pick_grant;
        grant_id_o <= pick_idx;
        busy_o <= 1'b1;
        stall_cnt <= '0;
      end else if (locked && state_n == ARB_IDLE) begin
        grant_o <= '0;
        busy_o <= 1'b0;
        ptr <= nxt_id;
        if (stall_to) timeout_id_o <= grant_id_o;
      end else if (locked) begin
        stall_cnt <= hs ? '0 : (!owner_valid && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; per-requester packet queues checked against a
// transaction-level round-robin model (owner, pointer, expected bytes)
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int DW = 9;
  typedef struct {
    logic [DW-1:0] data;
    logic last;
    int gap;
  } byte_t;

  logic clk = 1'b0, rst_n = 1'b0, enable_i = 1'b1, tx_d_ready_i = 1'b1;
  logic [N-1:0] req_ready_o, grant_o;
  logic [N*DW-1:0] req_data_i;
  logic [DW-1:0] tx_d_o;
  logic tx_d_valid_o, busy_o, timeout_o;
  logic [1:0] grant_id_o, timeout_id_o;
  logic [DW-1:0] rd [N] = '{default: '0};
  logic [N-1:0] rv = '0, rl = '0, fired = '0;
  byte_t pend [N][$];
  byte_t exp_q [N][$];
  int gap_cnt [N] = '{default: 0};
  int total = 0, bad = 0;
  int m_owner = -1, m_ptr = 0;
  bit mon_on = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data_i = '0;
    for (int r = 0; r < N; r++) req_data_i[r*DW +: DW] = rd[r];
  end

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i),
    .req_valid_i(rv), .req_data_i(req_data_i), .req_last_i(rl),
    .req_ready_o(req_ready_o), .tx_d_o(tx_d_o), .tx_d_valid_o(tx_d_valid_o),
    .tx_d_ready_i(tx_d_ready_i), .grant_o(grant_o), .grant_id_o(grant_id_o),
    .busy_o(busy_o), .timeout_o(timeout_o), .timeout_id_o(timeout_id_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic bit pend_empty();
    for (int r = 0; r < N; r++) if (pend[r].size() != 0) return 0;
    return 1;
  endfunction

  task automatic push(input int r, input logic [DW-1:0] d, input logic l, input int g);
    byte_t b;
    b.data = d;
    b.last = l;
    b.gap = g;
    pend[r].push_back(b);
  endtask

  task automatic push_pkt(input int r, input int len, input int gap0, input int gmax);
    for (int k = 0; k < len; k++)
      push(r, DW'($urandom), k == len - 1, k == 0 ? gap0 : int'($urandom_range(0, gmax)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!(rv == 0 && pend_empty() && grant_o == 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL wait_idle: no drain within %0d cycles", lim);
    end
    repeat (2) @(negedge clk);
  endtask

  // requester drivers: hold each byte until accepted, honour per-byte gaps
  initial begin : drv
    byte_t b;
    forever begin
      tick();
      for (int r = 0; r < N; r++) begin
        if (fired[r]) rv[r] = 1'b0;
        if (!rv[r] && pend[r].size() > 0) begin
          if (gap_cnt[r] < pend[r][0].gap) gap_cnt[r]++;
          else begin
            b = pend[r].pop_front();
            gap_cnt[r] = 0;
            rd[r] = b.data;
            rl[r] = b.last;
            rv[r] = 1'b1;
            exp_q[r].push_back(b);
          end
        end
      end
    end
  end

  // monitor: model decides owner from spec rules, scoreboard checks bytes
  always @(negedge clk) begin : mon
    int nxt;
    byte_t b;
    fired = rv & req_ready_o;
    if (mon_on && rst_n) begin
      nxt = m_owner;
      chk("grant", 32'(grant_o), m_owner < 0 ? 32'd0 : 32'd1 << m_owner);
      chk("busy", 32'(busy_o), 32'(m_owner >= 0));
      chk("ready", 32'(req_ready_o), (m_owner >= 0 && tx_d_ready_i) ? 32'd1 << m_owner : 32'd0);
      chk("tx_valid", 32'(tx_d_valid_o), 32'(m_owner >= 0 && rv[m_owner]));
      chk("no_timeout", 32'(timeout_o), 32'd0);
      if (m_owner >= 0) chk("grant_id", 32'(grant_id_o), 32'(m_owner));
      if (m_owner >= 0 && rv[m_owner]) begin
        if (exp_q[m_owner].size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: byte %0h from req %0d with nothing expected", tx_d_o, m_owner);
        end else begin
          chk("tx_data", 32'(tx_d_o), 32'(exp_q[m_owner][0].data));
          if (tx_d_ready_i) begin
            b = exp_q[m_owner].pop_front();
            if (b.last) begin
              m_ptr = (m_owner + 1) % N;
              nxt = -1;
            end
          end
        end
      end else if (m_owner < 0 && enable_i && rv != 0) nxt = rr_pick(rv, m_ptr);
      m_owner = nxt;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_grant_id", 32'(grant_id_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_tx_valid", 32'(tx_d_valid_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_timeout_id", 32'(timeout_id_o), 0);
    tick();
    rst_n = 1'b1;
    mon_on = 1;
    push(0, 9'h051, 1'b0, 0); push(0, 9'h152, 1'b1, 0);
    push(2, 9'h061, 1'b0, 0); push(2, 9'h162, 1'b1, 0);
    push_pkt(0, 2, 0, 0);
    push_pkt(2, 2, 0, 0);
    wait_idle(300);
    push(1, 9'h041, 1'b0, 0); push(1, 9'h042, 1'b0, 0); push(1, 9'h143, 1'b1, 0);
    wait_idle(100);
    push_pkt(3, 5, 0, 2);
    push_pkt(1, 2, 3, 0);
    wait_idle(300);
    push_pkt(0, 4, 0, 0);
    n = 0;
    while (!grant_o[0] && n < 50) begin @(negedge clk); n++; end
    chk("en_grant0", 32'(n < 50), 1);
    tick();
    enable_i = 1'b0;
    push_pkt(1, 1, 0, 0);
    repeat (30) @(negedge clk);
    chk("en_blocked", 32'(grant_o), 0);
    tick();
    enable_i = 1'b1;
    wait_idle(100);
    tick();
    tx_d_ready_i = 1'b0;
    push_pkt(2, 2, 0, 0);
    repeat (5000) @(negedge clk);
    tick();
    tx_d_ready_i = 1'b1;
    wait_idle(100);
    tick();
    mon_on = 0;
    push(2, 9'h0AA, 1'b0, 0);
    n = 0;
    while (!(rv[2] && req_ready_o[2]) && n < 50) begin @(negedge clk); n++; end
    chk("to_accept", 32'(n < 50), 1);
    tick();
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_o && n < 40);
    chk("to_latency", 32'(n), 17);
    chk("to_id", 32'(timeout_id_o), 2);
    chk("to_grant", 32'(grant_o), 0);
    chk("to_busy", 32'(busy_o), 0);
    @(negedge clk);
    chk("to_pulse", 32'(timeout_o), 0);
    for (int r = 0; r < N; r++) exp_q[r].delete();
    m_owner = -1;
    m_ptr = 3;
    tick();
    mon_on = 1;
    push(0, 9'h011, 1'b1, 0);
    push(3, 9'h133, 1'b1, 0);
    wait_idle(100);
    push(1, 9'h021, 1'b1, 0);
    wait_idle(100);
    push_pkt(2, 4, 0, 0);
    n = 0;
    while (!grant_o[2] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    tick();
    mon_on = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant_o), 0);
    chk("arst_grant_id", 32'(grant_id_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_tx_valid", 32'(tx_d_valid_o), 0);
    chk("arst_tx_data", 32'(tx_d_o), 0);
    chk("arst_ready", 32'(req_ready_o), 0);
    chk("arst_timeout_id", 32'(timeout_id_o), 0);
    for (int r = 0; r < N; r++) begin
      pend[r].delete();
      exp_q[r].delete();
      gap_cnt[r] = 0;
    end
    rv = '0;
    rl = '0;
    fired = '0;
    tick();
    tick();
    rst_n = 1'b1;
    m_owner = -1;
    m_ptr = 0;
    mon_on = 1;
    push(0, 9'h0C0, 1'b1, 0);
    push(2, 9'h0C2, 1'b1, 0);
    wait_idle(100);
    for (int r = 0; r < N; r++)
      repeat (40) push_pkt(r, $urandom_range(1, 4), $urandom_range(0, 6), 5);
    n = 0;
    while (!(pend_empty() && rv == 0 && grant_o == 0) && n < 30000) begin
      tick();
      tx_d_ready_i = $urandom_range(0, 3) != 0;
      enable_i = $urandom_range(0, 7) != 0;
      n++;
    end
    chk("rand_drain", 32'(n < 30000), 1);
    tick();
    tx_d_ready_i = 1'b1;
    enable_i = 1'b1;
    wait_idle(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
